// File: rtl/bin_to_seg_digits.sv
// Iterative double-dabble converter: 8-bit binary to three registered active-low
// 7-segment digit patterns (hundreds, tens, ones) with start/busy/done handshake.
module bin_to_seg_digits #(
  parameter int BLANK_LZ = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] value,
  input  logic [2:0] dp_mask,
  output logic       busy,
  output logic       done,
  output logic [7:0] seg0,
  output logic [7:0] seg1,
  output logic [7:0] seg2
);

  typedef enum logic [1:0] {IDLE, SHIFT, ENCODE} state_t;

  state_t      state;
  logic [7:0]  operand;
  logic [2:0]  dp_q;
  logic [11:0] bcd;
  logic [2:0]  cnt;
  logic [11:0] bcd_adj;
  logic        blank2;
  logic        blank1;

  function automatic logic [7:0] digit_code(input logic [3:0] d);
    logic [7:0] c;
    case (d)
      4'd0:    c = 8'hC0;
      4'd1:    c = 8'hF9;
      4'd2:    c = 8'hA4;
      4'd3:    c = 8'hB0;
      4'd4:    c = 8'h99;
      4'd5:    c = 8'h92;
      4'd6:    c = 8'h82;
      4'd7:    c = 8'hF8;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h90;
      default: c = 8'hFF;
    endcase
    return c;
  endfunction

  // Decimal point is applied after blanking so a blank digit can still show its dp.
  function automatic logic [7:0] encode_digit(input logic [3:0] d, input logic blank,
                                              input logic dp);
    logic [7:0] s;
    s = blank ? 8'hFF : digit_code(d);
    if (dp) s[7] = 1'b0;
    return s;
  endfunction

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  always_comb begin
    bcd_adj = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};
    blank2  = (BLANK_LZ != 0) && (bcd[11:8] == 4'd0);
    blank1  = (BLANK_LZ != 0) && (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      bcd   <= '0;
      cnt   <= '0;
      seg0  <= 8'hFF;
      seg1  <= 8'hFF;
      seg2  <= 8'hFF;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            operand <= value;
            dp_q    <= dp_mask;
            bcd     <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          {bcd, operand} <= {bcd_adj[10:0], operand, 1'b0};
          cnt            <= cnt + 3'd1;
          if (cnt == 3'd7) state <= ENCODE;
        end
        ENCODE: begin
          seg2  <= encode_digit(bcd[11:8], blank2, dp_q[2]);
          seg1  <= encode_digit(bcd[7:4], blank1, dp_q[1]);
          seg0  <= encode_digit(bcd[3:0], 1'b0, dp_q[0]);
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_seg_digits.sv
// Directed bench for bin_to_seg_digits: handshake timing, blanking, dp, busy
// start rejection, mid-conversion reset and a full 0..255 sweep.
module tb_bin_to_seg_digits;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] value;
  logic [2:0] dp_mask;
  logic       busy, done;
  logic [7:0] seg0, seg1, seg2;
  logic       busy_z, done_z;
  logic [7:0] segz0, segz1, segz2;

  int n_checks = 0;
  int n_fail   = 0;

  bin_to_seg_digits #(.BLANK_LZ(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .value(value), .dp_mask(dp_mask),
    .busy(busy), .done(done), .seg0(seg0), .seg1(seg1), .seg2(seg2)
  );

  bin_to_seg_digits #(.BLANK_LZ(0)) u_dut_nz (
    .clk(clk), .rst(rst), .start(start), .value(value), .dp_mask(dp_mask),
    .busy(busy_z), .done(done_z), .seg0(segz0), .seg1(segz1), .seg2(segz2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ref_digit(input int d);
    logic [7:0] t [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                           8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    return t[d];
  endfunction

  function automatic logic [23:0] ref_segs(input int v, input logic [2:0] dp, input bit blz);
    int h = v / 100;
    int t = (v / 10) % 10;
    int o = v % 10;
    logic [7:0] s2, s1, s0;
    s2 = (blz && h == 0) ? 8'hFF : ref_digit(h);
    s1 = (blz && h == 0 && t == 0) ? 8'hFF : ref_digit(t);
    s0 = ref_digit(o);
    if (dp[2]) s2[7] = 1'b0;
    if (dp[1]) s1[7] = 1'b0;
    if (dp[0]) s0[7] = 1'b0;
    return {s2, s1, s0};
  endfunction

  // One conversion: returns edges from acceptance to done, busy-high samples,
  // whether segs stayed put before done, and whether done lasted one cycle.
  task automatic convert(input logic [7:0] v, input logic [2:0] dp,
                         output int lat, output int busy_cyc,
                         output bit stable, output bit one_wide);
    logic [23:0] prev;
    prev = {seg2, seg1, seg0};
    value = v; dp_mask = dp; start = 1'b1;
    tick();
    start = 1'b0;
    value = ~v; dp_mask = ~dp;
    lat = 0; busy_cyc = 0; stable = 1'b1;
    while (!done && lat < 20) begin
      if (busy) busy_cyc++;
      if ({seg2, seg1, seg0} !== prev) stable = 1'b0;
      tick();
      lat++;
      if (!done && {seg2, seg1, seg0} !== prev) stable = 1'b0;
    end
    tick();
    one_wide = !done;
  endtask

  int lat, bc, acc_cnt, rise_edge, done_cnt;
  bit stb, ow, all_ok, busy_prev;
  logic [7:0] cap, drv;

  initial begin
    rst = 1'b1; start = 1'b1; value = 8'd55; dp_mask = 3'b000;
    tick(); tick();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_segs", 32'({seg2, seg1, seg0}), 32'h00FFFFFF);
    start = 1'b0;
    rst = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    convert(8'd0, 3'b000, lat, bc, stb, ow);
    check("v0_latency", 32'(lat), 32'd9);
    check("v0_busy_cycles", 32'(bc), 32'd9);
    check("v0_segs", 32'({seg2, seg1, seg0}), 32'h00FFFFC0);
    check("v0_done_width", 32'(ow), 32'd1);
    check("v0_stable", 32'(stb), 32'd1);

    convert(8'd255, 3'b000, lat, bc, stb, ow);
    check("v255_segs", 32'({seg2, seg1, seg0}), 32'h00A49292);
    check("v255_nz_segs", 32'({segz2, segz1, segz0}), 32'h00A49292);
    convert(8'd105, 3'b000, lat, bc, stb, ow);
    check("v105_segs", 32'({seg2, seg1, seg0}), 32'h00F9C092);
    convert(8'd9, 3'b101, lat, bc, stb, ow);
    check("v9dp_segs", 32'({seg2, seg1, seg0}), 32'h007FFF10);
    check("v9dp_nz_segs", 32'({segz2, segz1, segz0}), 32'h0040C010);
    convert(8'd37, 3'b000, lat, bc, stb, ow);
    check("v37_segs", 32'({seg2, seg1, seg0}), 32'h00FFB0F8);
    check("v37_nz_segs", 32'({segz2, segz1, segz0}), 32'h00C0B0F8);

    // start held high, value changing each cycle
    start = 1'b1; dp_mask = 3'b000; acc_cnt = 0; busy_prev = busy; cap = 8'd0;
    for (int i = 0; i < 40; i++) begin
      drv = 8'((i * 37 + 11) & 255);
      value = drv;
      tick();
      if (busy && !busy_prev) begin
        rise_edge = i;
        check("held_accept_edge", 32'(rise_edge), 32'(acc_cnt * 10));
        cap = drv;
        acc_cnt++;
      end
      if (done)
        check("held_result", 32'({seg2, seg1, seg0}), 32'(ref_segs(int'(cap), 3'b000, 1'b1)));
      busy_prev = busy;
    end
    check("held_accept_count", 32'(acc_cnt), 32'd4);
    start = 1'b0;
    for (int i = 0; i < 12 && busy; i++) tick();
    tick();
    check("held_drained", 32'(busy), 32'd0);

    // reset mid-conversion of 200 after a result of 37
    convert(8'd37, 3'b000, lat, bc, stb, ow);
    check("pre_rst_segs", 32'({seg2, seg1, seg0}), 32'h00FFB0F8);
    value = 8'd200; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    check("midrst_segs", 32'({seg2, seg1, seg0}), 32'h00FFFFFF);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) done_cnt++;
    end
    check("midrst_no_done", 32'(done_cnt), 32'd0);
    convert(8'd200, 3'b000, lat, bc, stb, ow);
    check("v200_latency", 32'(lat), 32'd9);
    check("v200_segs", 32'({seg2, seg1, seg0}), 32'h00A4C0C0);

    // full sweep, both blanking modes, varying dp
    all_ok = 1'b1;
    for (int v = 0; v < 256; v++) begin
      logic [2:0] dp;
      dp = 3'(v % 8);
      convert(8'(v), dp, lat, bc, stb, ow);
      if ({seg2, seg1, seg0} !== ref_segs(v, dp, 1'b1) ||
          {segz2, segz1, segz0} !== ref_segs(v, dp, 1'b0) ||
          lat != 9 || bc != 9 || !stb || !ow) begin
        all_ok = 1'b0;
        check("sweep_segs", 32'({seg2, seg1, seg0}), 32'(ref_segs(v, dp, 1'b1)));
        check("sweep_nz_segs", 32'({segz2, segz1, segz0}), 32'(ref_segs(v, dp, 1'b0)));
        check("sweep_timing", 32'({lat[7:0], bc[7:0], 7'd0, stb, 7'd0, ow}),
              32'({8'd9, 8'd9, 8'd1, 8'd1}));
      end
    end
    check("sweep_all", 32'(all_ok), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bin_to_seg_digits.md
Name: bin_to_seg_digits

Overview:
- Converts an 8-bit unsigned binary value (0..255) into three registered 7-segment patterns: hundreds, tens and ones.
- Sits directly upstream of the three-digit display multiplexer; seg2/seg1/seg0 drive its in2/in1/in0 inputs.
- Uses an iterative double-dabble (shift/add-3) engine with a start/busy/done handshake.
- Holds the last result stable between conversions so the multiplexer can scan it indefinitely.

Parameters:
- BLANK_LZ, 1, when 1 a leading-zero hundreds or tens digit is blanked; when 0 all three digits always show.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a conversion; sampled only in IDLE.
- value  input  8  unsigned binary operand; captured on the edge that accepts start.
- dp_mask  input  3  decimal-point request: bit0=ones, bit1=tens, bit2=hundreds; captured with value.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse; seg outputs are updated on the same edge.
- seg0  output  8  ones digit pattern.
- seg1  output  8  tens digit pattern.
- seg2  output  8  hundreds digit pattern.

Behaviour:
- Segment format (active-low): bit0=a .. bit6=g, bit7=dp; 1 means the segment is off.
- Blank digit is 8'hFF.
- Digit codes: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (hex, dp off).
- dp_mask bit set: clear bit7 of that digit's pattern. This applies to blanked digits too (gives 8'h7F).
- Reset values: seg0=seg1=seg2=8'hFF, busy=0, done=0, FSM=IDLE, BCD shift register and iteration counter cleared.
- FSM states: IDLE, SHIFT, ENCODE.
- IDLE:
  - On start=1: capture value and dp_mask, clear the 12-bit BCD register, set counter=0, busy<=1, go to SHIFT.
  - On start=0: stay in IDLE.
- SHIFT:
  - Each cycle, add 3 to every BCD nibble that is >=5, then shift {bcd, operand} left by 1.
  - Counter increments each cycle. After the 8th shift (counter==7) go to ENCODE.
- ENCODE:
  - Map the nibbles to patterns and apply blanking and dp.
  - Write seg0..seg2, assert done<=1 and busy<=0, return to IDLE.
- Latency:
  - Call the edge that accepts start edge 0. Shifts occur on edges 1..8; outputs and done update on edge 9.
  - busy is high after edge 0 through edge 9, where it falls as done rises.
  - Next start can be accepted on edge 10, i.e. while done is high.
  - Throughput: one conversion per 10 cycles.
- done is high for exactly one cycle and is never asserted outside ENCODE completion.
- Blanking with BLANK_LZ=1:
  - seg2 is blank when hundreds==0.
  - seg1 is blank when hundreds==0 and tens==0.
  - seg0 is never blank, so value 0 shows "0".
- start while busy is ignored: no queueing, captured operand unchanged, latency unaffected.
- value and dp_mask changes during busy have no effect.
- seg outputs change only on the ENCODE edge or on reset; no intermediate BCD values ever appear on them.
- Reset asserted mid-conversion aborts on that edge: outputs blank, busy=0, no done pulse.
- Reset takes priority over start in the same cycle.
- BCD nibbles never exceed 9 for inputs 0..255. Hundreds is at most 2; its upper 2 bits are always 0.

Test Plan:
- Reset, then value=0, dp_mask=0, BLANK_LZ=1, pulse start -> done pulse on edge 9; seg2=FF, seg1=FF, seg0=C0; busy high for exactly 9 cycles.
- value=255 -> seg2=A4, seg1=92, seg0=92. Then value=105 -> seg2=F9, seg1=C0 (tens zero not blanked), seg0=92.
- value=9, dp_mask=3'b101 -> seg2=7F (blank with dp), seg1=FF, seg0=10. With BLANK_LZ=0: seg2=40, seg1=C0, seg0=10.
- start held high continuously with value changing every cycle -> conversions accepted only on edges 0, 10, 20...; each result matches the value sampled at acceptance; mid-busy starts ignored.
- Assert rst on edge 4 of a conversion of 200 after a prior result of 37 -> all segs FF, busy 0, no done; next start with 200 -> seg2=A4, seg1=C0, seg0=C0.
- Exhaustive sweep 0..255 -> every result matches the reference digit decode, done is always exactly one cycle wide, segs never change between done pulses.
